// File: rtl/imem_loader.sv
// imem_loader: packs a byte stream big-endian into instruction words and
// writes them sequentially into the instruction memory, holding the CPU
// stalled until the image is complete.
// Optional feature: define IMEM_LOADER_CHKSUM_EN to add the chkSum output,
// a running XOR of every word written.
module imem_loader #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              counterRst,
  input  logic              inValid,
  input  logic [7:0]        inByte,
  input  logic              inLast,
  output logic              inReady,
  output logic              wrEn,
  output logic [ADDR_W-1:0] wrAddr,
  output logic [DATA_W-1:0] wrData,
  output logic              cpuHold,
  output logic              loadDone,
  output logic              errOverflow,
  output logic [ADDR_W:0]   wordCount
`ifdef IMEM_LOADER_CHKSUM_EN
  ,
  output logic [DATA_W-1:0] chkSum
`endif
);

  localparam int BYTES = DATA_W / 8;
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(BYTES - 1);
  localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } loaderState;

  loaderState        state;
  loaderState        stateNext;
  logic [IDX_W-1:0]  byteIdx;
  logic [DATA_W-1:0] shiftReg;
  logic [DATA_W-1:0] packNext;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   wordCnt;
  logic              lastSeen;
  logic              overflow;
  logic              accept;
  logic              wordEnds;

  // Handshake and word-completion decode; ready depends on state only.
  always_comb begin
    inReady  = (state == IDLE) || (state == COLLECT);
    accept   = inValid && inReady;
    wordEnds = inLast || (byteIdx == IDX_LAST);
  end

  // Drop the incoming byte into its big-endian lane; first byte is the MSB.
  always_comb begin
    packNext = shiftReg;
    for (int k = 0; k < BYTES; k++) begin
      if (byteIdx == IDX_W'(k)) begin
        packNext[DATA_W-1-8*k -: 8] = inByte;
      end else begin
        packNext[DATA_W-1-8*k -: 8] = shiftReg[DATA_W-1-8*k -: 8];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge counterRst) begin
    if (counterRst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // FSM next-state logic; the last memory slot ends the load even without inLast.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE, COLLECT: begin
        if (accept && wordEnds) begin
          stateNext = WRITE;
        end else if (accept) begin
          stateNext = COLLECT;
        end else begin
          stateNext = state;
        end
      end
      WRITE: begin
        if (lastSeen || (addr == ADDR_MAX)) begin
          stateNext = DONE;
        end else begin
          stateNext = COLLECT;
        end
      end
      DONE:    stateNext = DONE;
      default: stateNext = IDLE;
    endcase
  end

  // Packing, address/count advance and overflow flag; address saturates at the top.
  always_ff @(posedge clk or posedge counterRst) begin
    if (counterRst) begin
      byteIdx  <= '0;
      shiftReg <= '0;
      addr     <= '0;
      wordCnt  <= '0;
      lastSeen <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE, COLLECT: begin
          if (accept) begin
            shiftReg <= packNext;
            byteIdx  <= byteIdx + IDX_ONE;
            lastSeen <= inLast;
          end
        end
        WRITE: begin
          wordCnt  <= wordCnt + CNT_ONE;
          byteIdx  <= '0;
          shiftReg <= '0;
          lastSeen <= 1'b0;
          if (addr != ADDR_MAX) begin
            addr <= addr + ADDR_ONE;
          end
          if ((addr == ADDR_MAX) && !lastSeen) begin
            overflow <= 1'b1;
          end
        end
        default: begin
          byteIdx <= byteIdx;
        end
      endcase
    end
  end

`ifdef IMEM_LOADER_CHKSUM_EN
  logic [DATA_W-1:0] chkSumReg;

  // Running XOR of each written word, folded in on the edge closing WRITE.
  always_ff @(posedge clk or posedge counterRst) begin
    if (counterRst) begin
      chkSumReg <= '0;
    end else if (state == WRITE) begin
      chkSumReg <= chkSumReg ^ shiftReg;
    end
  end

  assign chkSum = chkSumReg;
`endif

  assign wrEn        = (state == WRITE);
  assign wrAddr      = addr;
  assign wrData      = shiftReg;
  assign cpuHold     = (state != DONE);
  assign loadDone    = (state == DONE);
  assign errOverflow = overflow;
  assign wordCount   = wordCnt;

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader.
module tb_imem_loader;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              counterRst;
  logic              inValid;
  logic [7:0]        inByte;
  logic              inLast;
  logic              inReady;
  logic              wrEn;
  logic [ADDR_W-1:0] wrAddr;
  logic [DATA_W-1:0] wrData;
  logic              cpuHold;
  logic              loadDone;
  logic              errOverflow;
  logic [ADDR_W:0]   wordCount;
`ifdef IMEM_LOADER_CHKSUM_EN
  logic [DATA_W-1:0] chkSum;
`endif

  int checks = 0;
  int failures = 0;
  logic [ADDR_W-1:0] capAddr[$];
  logic [DATA_W-1:0] capData[$];

  imem_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .counterRst(counterRst), .inValid(inValid), .inByte(inByte),
    .inLast(inLast), .inReady(inReady), .wrEn(wrEn), .wrAddr(wrAddr),
    .wrData(wrData), .cpuHold(cpuHold), .loadDone(loadDone),
    .errOverflow(errOverflow), .wordCount(wordCount)
`ifdef IMEM_LOADER_CHKSUM_EN
    , .chkSum(chkSum)
`endif
  );

  always #5 clk = ~clk;

  // Record every memory write, sampled mid-cycle.
  always @(negedge clk) begin
    if (wrEn === 1'b1) begin
      capAddr.push_back(wrAddr);
      capData.push_back(wrData);
    end
  end

  // Offer one byte starting at a falling edge; ok=1 once a rising edge accepts it.
  task automatic sendByte(input logic [7:0] b, input logic last, input int budget, output logic ok);
    ok = 1'b0;
    inValid = 1'b1;
    inByte = b;
    inLast = last;
    for (int t = 0; t < budget && !ok; t++) begin
      #1;
      if (inReady === 1'b1) ok = 1'b1;
      @(negedge clk);
    end
    inValid = 1'b0;
    inLast = 1'b0;
  endtask

  task automatic applyReset();
    @(negedge clk);
    counterRst = 1'b1;
    inValid = 1'b0;
    inLast = 1'b0;
    inByte = 8'h00;
    @(negedge clk);
    capAddr.delete();
    capData.delete();
    @(negedge clk);
    counterRst = 1'b0;
  endtask

  // Stream n bytes whose values are their own index; returns the number of stalls that timed out.
  task automatic streamImage(input int n, input logic lastOnFinal, output int timeouts);
    logic ok;
    timeouts = 0;
    for (int i = 0; i < n; i++) begin
      sendByte(8'(i), lastOnFinal && (i == n - 1), 10, ok);
      if (!ok) timeouts++;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    counterRst = 1'b1;
    inValid = 1'b0;
    inLast = 1'b0;
    inByte = 8'h00;
    @(negedge clk);
    checks++;
    if ({inReady, wrEn, wrAddr, wrData, cpuHold, loadDone, errOverflow, wordCount} !==
        {1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0, 6'd0}) begin
      failures++;
      $display("FAIL reset_outputs got rdy=%b we=%b a=%0d d=%h hold=%b done=%b ovf=%b cnt=%0d",
               inReady, wrEn, wrAddr, wrData, cpuHold, loadDone, errOverflow, wordCount);
    end
`ifdef IMEM_LOADER_CHKSUM_EN
    checks++;
    if (chkSum !== 32'h0) begin
      failures++;
      $display("FAIL reset_chkSum got=%h exp=00000000", chkSum);
    end
`endif
    @(negedge clk);
    counterRst = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if ({cpuHold, loadDone, inReady, wrEn} !== 4'b1010) begin
      failures++;
      $display("FAIL empty_image_held got hold=%b done=%b rdy=%b we=%b exp 1 0 1 0",
               cpuHold, loadDone, inReady, wrEn);
    end
  endtask

  task automatic test_basic();
    logic [7:0] b [8];
    logic ok;
    b = '{8'h20, 8'h01, 8'h00, 8'h05, 8'h8C, 8'h22, 8'h00, 8'h04};
    applyReset();
    for (int i = 0; i < 8; i++) begin
      sendByte(b[i], (i == 7), 10, ok);
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL basic_accept byte %0d not accepted within budget", i);
      end
      if (i == 3) begin
        checks++;
        if ({wrEn, wrAddr, wrData} !== {1'b1, 5'd0, 32'h20010005}) begin
          failures++;
          $display("FAIL basic_latency got we=%b a=%0d d=%h exp we=1 a=0 d=20010005", wrEn, wrAddr, wrData);
        end
      end
    end
    repeat (2) @(negedge clk);
    checks++;
    if (capData.size() != 2) begin
      failures++;
      $display("FAIL basic_writes got=%0d exp=2", capData.size());
    end else begin
      checks++;
      if ({capAddr[0], capData[0], capAddr[1], capData[1]} !== {5'd0, 32'h20010005, 5'd1, 32'h8C220004}) begin
        failures++;
        $display("FAIL basic_words got %0d:%h %0d:%h exp 0:20010005 1:8c220004",
                 capAddr[0], capData[0], capAddr[1], capData[1]);
      end
    end
    checks++;
    if ({loadDone, cpuHold, inReady, errOverflow, wordCount} !== {1'b1, 1'b0, 1'b0, 1'b0, 6'd2}) begin
      failures++;
      $display("FAIL basic_done got done=%b hold=%b rdy=%b ovf=%b cnt=%0d exp 1 0 0 0 2",
               loadDone, cpuHold, inReady, errOverflow, wordCount);
    end
    sendByte(8'h55, 1'b1, 4, ok);
    repeat (2) @(negedge clk);
    checks++;
    if (ok || capData.size() != 2 || wordCount !== 6'd2) begin
      failures++;
      $display("FAIL done_ignores_input got accepted=%b writes=%0d cnt=%0d exp 0 2 2", ok, capData.size(), wordCount);
    end
  endtask

  task automatic test_short_word();
    logic ok;
    applyReset();
    for (int i = 0; i < 6; i++) begin
      sendByte(8'h11 + 8'(i), (i == 5), 10, ok);
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL short_accept byte %0d not accepted", i);
      end
    end
    repeat (2) @(negedge clk);
    checks++;
    if (capData.size() != 2) begin
      failures++;
      $display("FAIL short_writes got=%0d exp=2", capData.size());
    end else begin
      checks++;
      if ({capAddr[0], capData[0], capAddr[1], capData[1]} !== {5'd0, 32'h11121314, 5'd1, 32'h15160000}) begin
        failures++;
        $display("FAIL short_words got %0d:%h %0d:%h exp 0:11121314 1:15160000",
                 capAddr[0], capData[0], capAddr[1], capData[1]);
      end
    end
    checks++;
    if ({loadDone, cpuHold, wordCount} !== {1'b1, 1'b0, 6'd2}) begin
      failures++;
      $display("FAIL short_done got done=%b hold=%b cnt=%0d exp 1 0 2", loadDone, cpuHold, wordCount);
    end
  endtask

  task automatic test_overflow();
    int timeouts;
    logic ok;
    logic [7:0] b0;
    logic [DATA_W-1:0] expWord;
    applyReset();
    streamImage(128, 1'b0, timeouts);
    checks++;
    if (timeouts != 0) begin
      failures++;
      $display("FAIL overflow_accept got timeouts=%0d exp=0", timeouts);
    end
    @(negedge clk);
    sendByte(8'hFF, 1'b0, 4, ok);
    checks++;
    if (ok) begin
      failures++;
      $display("FAIL overflow_byte129 got accepted=1 exp=0");
    end
    checks++;
    if (capData.size() != 32) begin
      failures++;
      $display("FAIL overflow_writes got=%0d exp=32", capData.size());
    end else begin
      for (int w = 0; w < 32; w++) begin
        b0 = 8'(4 * w);
        expWord = {b0, b0 + 8'd1, b0 + 8'd2, b0 + 8'd3};
        checks++;
        if (capAddr[w] !== 5'(w) || capData[w] !== expWord) begin
          failures++;
          $display("FAIL overflow_word%0d got %0d:%h exp %0d:%h", w, capAddr[w], capData[w], w, expWord);
        end
      end
    end
    checks++;
    if ({errOverflow, inReady, loadDone, cpuHold, wordCount} !== {1'b1, 1'b0, 1'b1, 1'b0, 6'd32}) begin
      failures++;
      $display("FAIL overflow_flags got ovf=%b rdy=%b done=%b hold=%b cnt=%0d exp 1 0 1 0 32",
               errOverflow, inReady, loadDone, cpuHold, wordCount);
    end
  endtask

  task automatic test_exact_fill();
    int timeouts;
    applyReset();
    streamImage(128, 1'b1, timeouts);
    repeat (2) @(negedge clk);
    checks++;
    if (timeouts != 0 || capData.size() != 32) begin
      failures++;
      $display("FAIL exact_fill_writes got timeouts=%0d writes=%0d exp 0 32", timeouts, capData.size());
    end
    checks++;
    if ({errOverflow, loadDone, cpuHold, wordCount} !== {1'b0, 1'b1, 1'b0, 6'd32}) begin
      failures++;
      $display("FAIL exact_fill_flags got ovf=%b done=%b hold=%b cnt=%0d exp 0 1 0 32",
               errOverflow, loadDone, cpuHold, wordCount);
    end
  endtask

  task automatic test_toggle_valid();
    logic [7:0] b [4];
    logic ok;
    b = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    applyReset();
    for (int i = 0; i < 4; i++) begin
      inValid = 1'b0;
      inByte = 8'hEE;
      @(negedge clk);
      sendByte(b[i], 1'b0, 10, ok);
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL toggle_accept byte %0d not accepted", i);
      end
    end
    repeat (3) @(negedge clk);
    checks++;
    if (capData.size() != 1) begin
      failures++;
      $display("FAIL toggle_writes got=%0d exp=1", capData.size());
    end else begin
      checks++;
      if ({capAddr[0], capData[0]} !== {5'd0, 32'hDEADBEEF}) begin
        failures++;
        $display("FAIL toggle_word got %0d:%h exp 0:deadbeef", capAddr[0], capData[0]);
      end
    end
    checks++;
    if ({wordCount, loadDone, cpuHold, inReady} !== {6'd1, 1'b0, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL toggle_state got cnt=%0d done=%b hold=%b rdy=%b exp 1 0 1 1",
               wordCount, loadDone, cpuHold, inReady);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b [4];
    logic ok;
    b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    applyReset();
    sendByte(8'h01, 1'b0, 10, ok);
    sendByte(8'h02, 1'b0, 10, ok);
    counterRst = 1'b1;
    @(negedge clk);
    checks++;
    if ({wrEn, wrData, wordCount, inReady} !== {1'b0, 32'h0, 6'd0, 1'b1}) begin
      failures++;
      $display("FAIL midreset_clear got we=%b d=%h cnt=%0d rdy=%b exp 0 00000000 0 1", wrEn, wrData, wordCount, inReady);
    end
    counterRst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sendByte(b[i], (i == 3), 10, ok);
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL midreset_accept byte %0d not accepted", i);
      end
    end
    repeat (2) @(negedge clk);
    checks++;
    if (capData.size() != 1) begin
      failures++;
      $display("FAIL midreset_writes got=%0d exp=1", capData.size());
    end else begin
      checks++;
      if ({capAddr[0], capData[0]} !== {5'd0, 32'hAABBCCDD}) begin
        failures++;
        $display("FAIL midreset_word got %0d:%h exp 0:aabbccdd", capAddr[0], capData[0]);
      end
    end
    checks++;
    if ({wordCount, loadDone} !== {6'd1, 1'b1}) begin
      failures++;
      $display("FAIL midreset_done got cnt=%0d done=%b exp 1 1", wordCount, loadDone);
    end
  endtask

`ifdef IMEM_LOADER_CHKSUM_EN
  task automatic test_chksum();
    logic [7:0] b [8];
    logic ok;
    b = '{8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00};
    applyReset();
    for (int i = 0; i < 8; i++) begin
      sendByte(b[i], (i == 7), 10, ok);
    end
    repeat (4) @(negedge clk);
    checks++;
    if ({chkSum, loadDone} !== {32'hFFFFFFFF, 1'b1}) begin
      failures++;
      $display("FAIL chksum got sum=%h done=%b exp ffffffff 1", chkSum, loadDone);
    end
  endtask
`endif

  // Bound the whole run in case the design never releases a handshake.
  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    counterRst = 1'b1;
    inValid = 1'b0;
    inLast = 1'b0;
    inByte = 8'h00;
    test_reset();
    test_basic();
    test_short_word();
    test_overflow();
    test_exact_fill();
    test_toggle_valid();
    test_reset_mid();
`ifdef IMEM_LOADER_CHKSUM_EN
    test_chksum();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
